// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump/load controller.
package regfile_dump_ctrl_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HALT = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_LOAD = 3'd4,
    ST_DONE = 3'd5
  } rf_dump_state_e;

  // Operation mode captured together with the start request
  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  // First register index of a walk; r0 is skipped when it is hardwired to zero
  function automatic int unsigned first_index(input int unsigned skip_r0);
    return (skip_r0 != 0) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Debug-side register file walker: halts core writeback, then streams every
// register out over a valid/ready channel. Optional load mode (macro
// RF_DUMP_LOAD_EN) restores registers from an input stream instead.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SKIP_R0        = 1
) (
  input  logic                      Clk_i,
  input  logic                      Rst_i,
  input  logic                      Start_i,
  input  logic                      Abort_i,
  output logic                      Halt_Req_o,
  input  logic                      Halt_Ack_i,
  output logic                      Busy_o,
  output logic                      Done_o,
  output logic [REG_ADDR_WIDTH-1:0] Rf_Sel_o,
  input  logic [REG_WIDTH-1:0]      Rf_Data_i,
`ifdef RF_DUMP_LOAD_EN
  input  logic                      Mode_i,
  input  logic                      Load_Valid_i,
  output logic                      Load_Ready_o,
  input  logic [REG_WIDTH-1:0]      Load_Data_i,
  output logic                      Rf_We_o,
  output logic [REG_ADDR_WIDTH-1:0] Rf_Wsel_o,
  output logic [REG_WIDTH-1:0]      Rf_Wdata_o,
`endif
  output logic                      Dump_Valid_o,
  input  logic                      Dump_Ready_i,
  output logic [REG_ADDR_WIDTH-1:0] Dump_Idx_o,
  output logic [REG_WIDTH-1:0]      Dump_Data_o
);

  localparam int unsigned REG_COUNT = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] FIRST_IDX = REG_ADDR_WIDTH'(first_index(SKIP_R0));
  localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX  = REG_ADDR_WIDTH'(REG_COUNT - 1);

  rf_dump_state_e              state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                        halt_q, halt_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0]   didx_q, didx_d;
  logic [REG_WIDTH-1:0]        ddata_q, ddata_d;
`ifdef RF_DUMP_LOAD_EN
  logic                        mode_q, mode_d;
  logic                        lready_q, lready_d;
  logic                        load_acc;

  assign load_acc = Load_Valid_i & lready_q;
`endif

  // State register
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, walk index and output register next values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    halt_d  = halt_q;
    valid_d = valid_q;
    didx_d  = didx_q;
    ddata_d = ddata_q;
`ifdef RF_DUMP_LOAD_EN
    mode_d  = mode_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          state_d = ST_HALT;
          halt_d  = 1'b1;
          idx_d   = FIRST_IDX;
`ifdef RF_DUMP_LOAD_EN
          mode_d  = Mode_i;
`endif
        end
      end
      ST_HALT: begin
        if (Halt_Ack_i) begin
`ifdef RF_DUMP_LOAD_EN
          state_d = (mode_q == MODE_LOAD) ? ST_LOAD : ST_READ;
`else
          state_d = ST_READ;
`endif
        end
      end
      ST_READ: begin
        ddata_d = Rf_Data_i;
        didx_d  = idx_q;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (Dump_Ready_i) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + REG_ADDR_WIDTH'(1);
            state_d = ST_READ;
          end
        end
      end
`ifdef RF_DUMP_LOAD_EN
      ST_LOAD: begin
        if (load_acc) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + REG_ADDR_WIDTH'(1);
          end
        end
      end
`endif
      ST_DONE: begin
        halt_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        halt_d  = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any transition, including a beat accepted this cycle
    if (Abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      halt_d  = 1'b0;
      valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
`ifdef RF_DUMP_LOAD_EN
    lready_d = (state_d == ST_LOAD);
`endif
  end

  // Walk index and registered outputs
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      idx_q    <= '0;
      halt_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      didx_q   <= '0;
      ddata_q  <= '0;
`ifdef RF_DUMP_LOAD_EN
      mode_q   <= MODE_DUMP;
      lready_q <= 1'b0;
`endif
    end else begin
      idx_q    <= idx_d;
      halt_q   <= halt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      didx_q   <= didx_d;
      ddata_q  <= ddata_d;
`ifdef RF_DUMP_LOAD_EN
      mode_q   <= mode_d;
      lready_q <= lready_d;
`endif
    end
  end

  assign Halt_Req_o   = halt_q;
  assign Busy_o       = busy_q;
  assign Done_o       = done_q;
  assign Rf_Sel_o     = idx_q;
  assign Dump_Valid_o = valid_q;
  assign Dump_Idx_o   = didx_q;
  assign Dump_Data_o  = ddata_q;

`ifdef RF_DUMP_LOAD_EN
  // Write port is driven only while loading so it idles at zero otherwise
  assign Load_Ready_o = lready_q;
  assign Rf_We_o      = load_acc;
  assign Rf_Wsel_o    = lready_q ? idx_q : '0;
  assign Rf_Wdata_o   = lready_q ? Load_Data_i : '0;
`endif

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: attaches a register file array, drives directed
// dump/abort/reset/load scenarios and checks every beat against the array contents.
module tb_regfile_dump_ctrl;

  localparam int unsigned RC = 32;

  logic        Clk_i = 1'b0;
  logic        Rst_i, Start_i, Abort_i, Halt_Ack_i, Dump_Ready_i;
  logic        Halt_Req_o, Busy_o, Done_o, Dump_Valid_o;
  logic [4:0]  Rf_Sel_o, Dump_Idx_o;
  logic [31:0] Rf_Data_i, Dump_Data_o;

  logic        start0, abort0, halt0, busy0, done0, valid0;
  logic [4:0]  sel0, idx0;
  logic [31:0] rdata0, data0;

`ifdef RF_DUMP_LOAD_EN
  logic        Mode_i, Load_Valid_i, Load_Ready_o, Rf_We_o;
  logic [31:0] Load_Data_i, Rf_Wdata_o;
  logic [4:0]  Rf_Wsel_o;
  logic        mode0, lvalid0, lready0, we0;
  logic [31:0] ldata0, wdata0;
  logic [4:0]  wsel0;
`endif

  logic [31:0] rf_mem [RC];
  logic        preload_req;

  int checks = 0;
  int errors = 0;

  always #5 Clk_i = ~Clk_i;

  assign Rf_Data_i = rf_mem[Rf_Sel_o];
  assign rdata0    = rf_mem[sel0];

  regfile_dump_ctrl #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5), .SKIP_R0(1)) u_dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Start_i(Start_i), .Abort_i(Abort_i),
    .Halt_Req_o(Halt_Req_o), .Halt_Ack_i(Halt_Ack_i), .Busy_o(Busy_o), .Done_o(Done_o),
    .Rf_Sel_o(Rf_Sel_o), .Rf_Data_i(Rf_Data_i),
`ifdef RF_DUMP_LOAD_EN
    .Mode_i(Mode_i), .Load_Valid_i(Load_Valid_i), .Load_Ready_o(Load_Ready_o),
    .Load_Data_i(Load_Data_i), .Rf_We_o(Rf_We_o), .Rf_Wsel_o(Rf_Wsel_o), .Rf_Wdata_o(Rf_Wdata_o),
`endif
    .Dump_Valid_o(Dump_Valid_o), .Dump_Ready_i(Dump_Ready_i),
    .Dump_Idx_o(Dump_Idx_o), .Dump_Data_o(Dump_Data_o)
  );

  regfile_dump_ctrl #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5), .SKIP_R0(0)) u_dut0 (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Start_i(start0), .Abort_i(abort0),
    .Halt_Req_o(halt0), .Halt_Ack_i(Halt_Ack_i), .Busy_o(busy0), .Done_o(done0),
    .Rf_Sel_o(sel0), .Rf_Data_i(rdata0),
`ifdef RF_DUMP_LOAD_EN
    .Mode_i(mode0), .Load_Valid_i(lvalid0), .Load_Ready_o(lready0),
    .Load_Data_i(ldata0), .Rf_We_o(we0), .Rf_Wsel_o(wsel0), .Rf_Wdata_o(wdata0),
`endif
    .Dump_Valid_o(valid0), .Dump_Ready_i(Dump_Ready_i),
    .Dump_Idx_o(idx0), .Dump_Data_o(data0)
  );

  // Register file: preload pattern, r0 hardwired to zero, write port from the load path
  always @(posedge Clk_i) begin
    if (preload_req) begin
      for (int i = 0; i < RC; i++) rf_mem[i] <= (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i);
    end
`ifdef RF_DUMP_LOAD_EN
    else if (Rf_We_o && (Rf_Wsel_o != 5'd0)) begin
      rf_mem[Rf_Wsel_o] <= Rf_Wdata_o;
    end
`endif
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: the next register the walk must deliver, plus logs of delivered beats
  int          exp_idx = 1;
  logic        prev_hold = 1'b0, prev_done = 1'b0;
  logic [4:0]  prev_idx = '0;
  logic [31:0] prev_data = '0;
  int          done_cnt = 0, we_cnt = 0, done0_cnt = 0;
  logic [4:0]  log_idx[$];
  logic [31:0] log_data[$];
  logic [4:0]  log0_idx[$];
  logic [31:0] log0_data[$];

  function automatic logic [63:0] lidx(input int k);
    return (k < log_idx.size()) ? 64'(log_idx[k]) : 64'hBAD;
  endfunction
  function automatic logic [63:0] ldat(input int k);
    return (k < log_data.size()) ? 64'(log_data[k]) : 64'hBAD;
  endfunction
  function automatic logic [63:0] l0idx(input int k);
    return (k < log0_idx.size()) ? 64'(log0_idx[k]) : 64'hBAD;
  endfunction
  function automatic logic [63:0] l0dat(input int k);
    return (k < log0_data.size()) ? 64'(log0_data[k]) : 64'hBAD;
  endfunction

  // Compare process: mid-cycle view of what the next edge will see
  always @(negedge Clk_i) begin
    if (Rst_i) begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
      exp_idx   = 1;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(Dump_Valid_o), 64'd1);
        chk("hold_idx", 64'(Dump_Idx_o), 64'(prev_idx));
        chk("hold_data", 64'(Dump_Data_o), 64'(prev_data));
      end
      if (Dump_Valid_o) begin
        chk("beat_idx", 64'(Dump_Idx_o), 64'(exp_idx));
        chk("beat_data", 64'(Dump_Data_o), 64'(rf_mem[Dump_Idx_o]));
      end
      if (Dump_Valid_o && Dump_Ready_i && !Abort_i) begin
        log_idx.push_back(Dump_Idx_o);
        log_data.push_back(Dump_Data_o);
        exp_idx++;
      end
`ifdef RF_DUMP_LOAD_EN
      if (Rf_We_o) begin
        chk("load_sel", 64'(Rf_Wsel_o), 64'(exp_idx));
        chk("load_data", 64'(Rf_Wdata_o), 64'(Load_Data_i));
        we_cnt++;
        exp_idx++;
      end
`endif
      if (Done_o) begin
        chk("done_after_last", 64'(exp_idx), 64'(RC));
        chk("done_single_cycle", 64'(prev_done), 64'd0);
        done_cnt++;
      end
      if (Start_i && !Busy_o) exp_idx = 1;
      prev_hold = Dump_Valid_o && !Dump_Ready_i && !Abort_i;
      prev_idx  = Dump_Idx_o;
      prev_data = Dump_Data_o;
      prev_done = Done_o;

      if (valid0 && Dump_Ready_i) begin
        chk("beat0_data", 64'(data0), 64'(rf_mem[idx0]));
        log0_idx.push_back(idx0);
        log0_data.push_back(data0);
      end
      if (done0) done0_cnt++;
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic pulse_start();
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
  endtask

  task automatic clear_logs();
    log_idx.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int max, input string name, input bit rand_ready);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      if (rand_ready) Dump_Ready_i = 1'($urandom_range(0, 1));
      tick();
      if (Done_o) begin
        seen = 1'b1;
        chk({name, "_halt_in_done"}, 64'(Halt_Req_o), 64'd1);
      end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    bit ok;
    bit seen;
    Rst_i = 1'b1; Start_i = 1'b0; Abort_i = 1'b0; Halt_Ack_i = 1'b0; Dump_Ready_i = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; preload_req = 1'b1;
`ifdef RF_DUMP_LOAD_EN
    Mode_i = 1'b0; Load_Valid_i = 1'b0; Load_Data_i = '0;
    mode0 = 1'b0; lvalid0 = 1'b0; ldata0 = '0;
`endif
    tick();
    tick();
    preload_req = 1'b0;

    // Reset values
    chk("rst_halt", 64'(Halt_Req_o), 64'd0);
    chk("rst_busy", 64'(Busy_o), 64'd0);
    chk("rst_done", 64'(Done_o), 64'd0);
    chk("rst_valid", 64'(Dump_Valid_o), 64'd0);
    chk("rst_idx", 64'(Dump_Idx_o), 64'd0);
    chk("rst_data", 64'(Dump_Data_o), 64'd0);
    chk("rst_sel", 64'(Rf_Sel_o), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    Rst_i = 1'b0;
    tick();

    // Full dump, ready tied high, halt ack three cycles after start
    clear_logs();
    Dump_Ready_i = 1'b1;
    pulse_start();
    chk("start_halt_req", 64'(Halt_Req_o), 64'd1);
    chk("start_busy", 64'(Busy_o), 64'd1);
    tick();
    tick();
    chk("no_beat_before_ack", 64'(Dump_Valid_o), 64'd0);
    Halt_Ack_i = 1'b1;
    wait_done(200, "full", 1'b0);
    chk("full_beats", 64'(log_idx.size()), 64'd31);
    chk("full_first_idx", lidx(0), 64'd1);
    chk("full_first_data", ldat(0), 64'hA000_0001);
    chk("full_last_idx", lidx(30), 64'd31);
    chk("full_last_data", ldat(30), 64'hA000_001F);
    tick();
    chk("full_halt_drop", 64'(Halt_Req_o), 64'd0);
    chk("full_busy_drop", 64'(Busy_o), 64'd0);
    chk("full_done_drop", 64'(Done_o), 64'd0);
    chk("full_done_cnt", 64'(done_cnt), 64'd1);

    // Random backpressure with a start pulse while busy
    clear_logs();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      Dump_Ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
    wait_done(600, "rand", 1'b1);
    Dump_Ready_i = 1'b1;
    ok = (log_idx.size() == 31);
    for (int k = 0; k < log_idx.size(); k++) if (log_idx[k] != 5'(k + 1)) ok = 1'b0;
    chk("rand_order", 64'(ok), 64'd1);
    tick();
    chk("rand_done_cnt", 64'(done_cnt), 64'd1);

    // Abort at beat 7 while stalled, then restart
    clear_logs();
    pulse_start();
    chk("lat_halt_valid", 64'(Dump_Valid_o), 64'd0);
    tick();
    chk("lat_read_valid", 64'(Dump_Valid_o), 64'd0);
    tick();
    chk("lat_send_valid", 64'(Dump_Valid_o), 64'd1);
    chk("lat_send_idx", 64'(Dump_Idx_o), 64'd1);
    chk("lat_send_data", 64'(Dump_Data_o), 64'hA000_0001);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      seen = Dump_Valid_o && (Dump_Idx_o == 5'd7);
      Dump_Ready_i = !seen;
      if (!seen) tick();
    end
    chk("abort_reach_7", 64'(seen), 64'd1);
    tick();
    tick();
    Abort_i = 1'b1;
    tick();
    Abort_i = 1'b0;
    chk("abort_valid", 64'(Dump_Valid_o), 64'd0);
    chk("abort_halt", 64'(Halt_Req_o), 64'd0);
    chk("abort_busy", 64'(Busy_o), 64'd0);
    chk("abort_beats", 64'(log_idx.size()), 64'd6);
    tick();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    clear_logs();
    Dump_Ready_i = 1'b1;
    pulse_start();
    wait_done(200, "restart", 1'b0);
    chk("restart_first_idx", lidx(0), 64'd1);
    chk("restart_beats", 64'(log_idx.size()), 64'd31);
    tick();

    // Reset in the middle of a stalled beat
    clear_logs();
    Dump_Ready_i = 1'b0;
    pulse_start();
    tick();
    tick();
    chk("pre_rst_valid", 64'(Dump_Valid_o), 64'd1);
    Rst_i = 1'b1;
    tick();
    chk("mrst_halt", 64'(Halt_Req_o), 64'd0);
    chk("mrst_busy", 64'(Busy_o), 64'd0);
    chk("mrst_done", 64'(Done_o), 64'd0);
    chk("mrst_valid", 64'(Dump_Valid_o), 64'd0);
    chk("mrst_idx", 64'(Dump_Idx_o), 64'd0);
    chk("mrst_data", 64'(Dump_Data_o), 64'd0);
    chk("mrst_sel", 64'(Rf_Sel_o), 64'd0);
    Rst_i = 1'b0;
    tick();
    chk("mrst_stay_idle", 64'(Busy_o), 64'd0);
    chk("mrst_no_done", 64'(done_cnt), 64'd0);

    // Walk including r0
    log0_idx.delete();
    log0_data.delete();
    done0_cnt = 0;
    Dump_Ready_i = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = done0;
    end
    chk("r0_done_seen", 64'(seen), 64'd1);
    tick();
    chk("r0_beats", 64'(log0_idx.size()), 64'd32);
    chk("r0_first_idx", l0idx(0), 64'd0);
    chk("r0_first_data", l0dat(0), 64'd0);
    chk("r0_last_idx", l0idx(31), 64'd31);
    chk("r0_last_data", l0dat(31), 64'hA000_001F);
    chk("r0_done_cnt", 64'(done0_cnt), 64'd1);
    chk("r0_halt_drop", 64'(halt0), 64'd0);
    chk("r0_busy_drop", 64'(busy0), 64'd0);

`ifdef RF_DUMP_LOAD_EN
    // Load r1..r31 from a gappy stream, then dump them back
    begin
      int nxt;
      bit acc;
      clear_logs();
      we_cnt = 0;
      nxt = 1;
      Mode_i = 1'b1;
      pulse_start();
      Mode_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        Load_Valid_i = ($urandom_range(0, 2) != 0);
        Load_Data_i  = 32'h5555_0000 + 32'(nxt);
        acc = Load_Valid_i && Load_Ready_o;
        tick();
        if (acc) nxt++;
        seen = Done_o;
      end
      Load_Valid_i = 1'b0;
      chk("load_done_seen", 64'(seen), 64'd1);
      chk("load_we_cnt", 64'(we_cnt), 64'd31);
      chk("load_accepts", 64'(nxt), 64'd32);
      tick();
      ok = (rf_mem[0] == 32'h0);
      for (int k = 1; k < RC; k++) if (rf_mem[k] != 32'h5555_0000 + 32'(k)) ok = 1'b0;
      chk("load_rf_contents", 64'(ok), 64'd1);
      chk("load_ready_drop", 64'(Load_Ready_o), 64'd0);
      clear_logs();
      pulse_start();
      wait_done(200, "readback", 1'b0);
      chk("readback_beats", 64'(log_idx.size()), 64'd31);
      chk("readback_first", ldat(0), 64'h5555_0001);
      chk("readback_last", ldat(30), 64'h5555_001F);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
